// File: rtl/display_pio_pkg.sv
// Register map and block decode shared by the multi-channel display PIO.
// Address layout is {blk, reg[2:0]}; blk selects a channel or the global block.
package display_pio_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_SET    = 3'd1;
  localparam logic [2:0] REG_CLEAR  = 3'd2;
  localparam logic [2:0] REG_TOGGLE = 3'd3;
  localparam logic [2:0] REG_MASK   = 3'd4;

  localparam logic [2:0] GREG_DIV    = 3'd0;
  localparam logic [2:0] GREG_STATUS = 3'd1;

  typedef enum logic [1:0] {
    BLK_CHAN,
    BLK_GLOBAL,
    BLK_NONE
  } blk_kind_e;

  function automatic blk_kind_e decode_blk(input int unsigned blk, input int unsigned num_ch);
    if (blk < num_ch) return BLK_CHAN;
    if (blk == num_ch) return BLK_GLOBAL;
    return BLK_NONE;
  endfunction

endpackage

// File: rtl/display_blink_timer.sv
// Blink prescaler: counts 0..div and flips the phase on each wrap.
// A write of the divider restarts the count and phase, overriding any coincident wrap.
module display_blink_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             div_wr,
  output logic             phase
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (div_wr || div == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/display_pio_multi.sv
// Multi-channel Avalon-MM display output port with atomic set/clear/toggle
// and per-bit hardware blink; readback and pins are both registered.
module display_pio_multi
  import display_pio_pkg::*;
#(
  parameter int              NUM_CH    = 4,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic            IDLE_LVL  = 1'b1,
  parameter int              DIV_W     = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_CH+1)+2:0]  address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic                         read_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [NUM_CH*DATA_W-1:0]     out_port,
  output logic                         blink_phase
);

  localparam int AW = $clog2(NUM_CH + 1) + 3;
  localparam int BW = AW - 3;

  logic            wr_en, rd_en;
  logic [BW-1:0]   blk;
  logic [2:0]      rsel;
  blk_kind_e       kind;
  logic [DATA_W-1:0] wdata;

  assign wr_en = chipselect && !write_n;
  assign rd_en = chipselect && !read_n;
  assign blk   = address[AW-1:3];
  assign rsel  = address[2:0];
  assign kind  = decode_blk(32'(blk), NUM_CH);
  assign wdata = writedata[DATA_W-1:0];

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_wr;

  assign div_wr = wr_en && (kind == BLK_GLOBAL) && (rsel == GREG_DIV);

  always_comb begin
    div_d = div_q;
    if (div_wr) div_d = writedata[DIV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  display_blink_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .div    (div_q),
    .div_wr (div_wr),
    .phase  (blink_phase)
  );

  logic [NUM_CH*DATA_W-1:0] data_all, mask_all;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] data_q, data_d, mask_q, mask_d, out_q, out_d;
    logic              sel;

    assign sel = wr_en && (kind == BLK_CHAN) && (blk == BW'(ch));

    always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      if (sel) begin
        case (rsel)
          REG_DATA:   data_d = wdata;
          REG_SET:    data_d = data_q | wdata;
          REG_CLEAR:  data_d = data_q & ~wdata;
          REG_TOGGLE: data_d = data_q ^ wdata;
          REG_MASK:   mask_d = wdata;
          default:    ;
        endcase
      end
    end

    // Masked bits are forced to the idle level during the off phase.
    always_comb begin
      out_d = blink_phase ? ((data_q & ~mask_q) | ({DATA_W{IDLE_LVL}} & mask_q)) : data_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= RESET_VAL;
        mask_q <= '0;
        out_q  <= RESET_VAL;
      end else begin
        data_q <= data_d;
        mask_q <= mask_d;
        out_q  <= out_d;
      end
    end

    assign data_all[ch*DATA_W +: DATA_W] = data_q;
    assign mask_all[ch*DATA_W +: DATA_W] = mask_q;
    assign out_port[ch*DATA_W +: DATA_W] = out_q;
  end

  logic [31:0] rdata_q, rdata_d;

  // Reads use current register state, so a combined write+read returns the pre-write value.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      if (kind == BLK_CHAN) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (blk == BW'(ch)) begin
            if (rsel == REG_DATA)      rdata_d = 32'(data_all[ch*DATA_W +: DATA_W]);
            else if (rsel == REG_MASK) rdata_d = 32'(mask_all[ch*DATA_W +: DATA_W]);
          end
        end
      end else if (kind == BLK_GLOBAL) begin
        if (rsel == GREG_DIV)         rdata_d = 32'(div_q);
        else if (rsel == GREG_STATUS) rdata_d = {31'b0, blink_phase};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_display_pio_multi.sv
// Scoreboard bench for display_pio_multi: read expectations are queued when a
// read is issued and retired when readdata appears one cycle later.
module tb_display_pio_multi;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DIV_W  = 24;
  localparam int AW     = $clog2(NUM_CH + 1) + 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [AW-1:0]            address;
  logic                     chipselect, write_n, read_n;
  logic [31:0]              writedata, readdata;
  logic [NUM_CH*DATA_W-1:0] out_port;
  logic                     blink_phase;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  display_pio_multi #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RESET_VAL(32'hA5), .IDLE_LVL(1'b1), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [AW-1:0] adr(input int blk, input int r);
    return AW'((blk << 3) | r);
  endfunction

  function automatic logic [31:0] chan(input int ch);
    return out_port[ch*DATA_W +: DATA_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [31:0] exp, output logic [31:0] got);
    exp_q.push_back(exp);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    tick();
    got = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (out_port !== {NUM_CH{32'hA5}}) begin n_errors++; $display("[TB] FAIL reset_out_port: got %h expected %h", out_port, {NUM_CH{32'hA5}}); end
    n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_readdata: got %h expected 0", readdata); end
    n_checks++; if (blink_phase !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_phase: got %b expected 0", blink_phase); end
    reset = 1'b0;
    bus_read(adr(2, 0), 32'hA5, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL reset_data2_read: got %h expected %h", got, e); end
  endtask

  task automatic test_atomics();
    int          regs[4] = '{0, 1, 2, 3};
    logic [31:0] vals[4] = '{32'h00F0, 32'h000F, 32'h0030, 32'h0101};
    logic [31:0] model, prev, got, e;
    model = 32'hA5;
    for (int i = 0; i < 4; i++) begin
      prev = model;
      case (regs[i])
        0:       model = vals[i];
        1:       model = model | vals[i];
        2:       model = model & ~vals[i];
        default: model = model ^ vals[i];
      endcase
      bus_write(adr(1, regs[i]), vals[i]);
      n_checks++; if (chan(1) !== prev) begin n_errors++; $display("[TB] FAIL atomic_pin_lag op%0d: got %h expected %h", i, chan(1), prev); end
      tick();
      n_checks++; if (chan(1) !== model) begin n_errors++; $display("[TB] FAIL atomic_pin op%0d: got %h expected %h", i, chan(1), model); end
    end
    n_checks++; if (chan(0) !== 32'hA5) begin n_errors++; $display("[TB] FAIL atomic_other_ch: got %h expected a5", chan(0)); end
    bus_read(adr(1, 0), 32'h01CE, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL atomic_data_read: got %h expected %h", got, e); end
    bus_read(adr(1, 1), 32'h0, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL set_reads_zero: got %h expected %h", got, e); end
    bus_read(adr(1, 3), 32'h0, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL toggle_reads_zero: got %h expected %h", got, e); end
  endtask

  task automatic test_blink();
    logic        ph, ph_prev;
    logic [31:0] exp_pin;
    bus_write(adr(0, 4), 32'hFF);
    bus_write(adr(0, 0), 32'h0);
    bus_write(adr(4, 0), 32'd3);
    for (int k = 1; k <= 16; k++) begin
      ph_prev = 1'(((k - 1) >> 2) & 1);
      ph      = 1'((k >> 2) & 1);
      exp_pin = ph_prev ? 32'hFF : 32'h0;
      tick();
      n_checks++; if (blink_phase !== ph) begin n_errors++; $display("[TB] FAIL blink_phase k=%0d: got %b expected %b", k, blink_phase, ph); end
      n_checks++; if (chan(0) !== exp_pin) begin n_errors++; $display("[TB] FAIL blink_pin k=%0d: got %h expected %h", k, chan(0), exp_pin); end
    end
  endtask

  task automatic test_div_write();
    int seen_high;
    bus_write(adr(4, 0), 32'd3);
    repeat (3) tick();
    bus_write(adr(4, 0), 32'd5);
    n_checks++; if (blink_phase !== 1'b0) begin n_errors++; $display("[TB] FAIL div_wr_beats_wrap: got %b expected 0", blink_phase); end
    repeat (5) tick();
    n_checks++; if (blink_phase !== 1'b0) begin n_errors++; $display("[TB] FAIL div5_hold: got %b expected 0", blink_phase); end
    tick();
    n_checks++; if (blink_phase !== 1'b1) begin n_errors++; $display("[TB] FAIL div5_toggle: got %b expected 1", blink_phase); end
    repeat (3) tick();
    bus_write(adr(4, 0), 32'd5);
    n_checks++; if (blink_phase !== 1'b0) begin n_errors++; $display("[TB] FAIL div_wr_mid_count: got %b expected 0", blink_phase); end
    repeat (5) tick();
    n_checks++; if (blink_phase !== 1'b0) begin n_errors++; $display("[TB] FAIL div_restart_hold: got %b expected 0", blink_phase); end
    tick();
    n_checks++; if (blink_phase !== 1'b1) begin n_errors++; $display("[TB] FAIL div_restart_toggle: got %b expected 1", blink_phase); end
    bus_write(adr(4, 0), 32'd0);
    seen_high = 0;
    for (int k = 0; k < 10; k++) begin
      if (blink_phase !== 1'b0) seen_high++;
      tick();
    end
    n_checks++; if (seen_high != 0) begin n_errors++; $display("[TB] FAIL div0_phase_held: got %0d high cycles expected 0", seen_high); end
  endtask

  task automatic test_read_decode();
    logic [31:0] got, e;
    bus_write(adr(0, 0), 32'h1234_5678);
    bus_write(adr(4, 0), 32'hAB00_0002);
    repeat (3) tick();
    chipselect = 1'b1; read_n = 1'b0;
    address = adr(0, 0); exp_q.push_back(32'h1234_5678); tick(); got = readdata; e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL b2b_data0: got %h expected %h", got, e); end
    address = adr(4, 1); exp_q.push_back(32'h1); tick(); got = readdata; e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL b2b_status: got %h expected %h", got, e); end
    address = adr(5, 0); exp_q.push_back(32'h0); tick(); got = readdata; e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL b2b_unmapped: got %h expected %h", got, e); end
    chipselect = 1'b0; read_n = 1'b1;
    tick();
    n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("[TB] FAIL readdata_idle: got %h expected 0", readdata); end
    bus_read(adr(4, 0), 32'h2, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL div_width_read: got %h expected %h", got, e); end
    bus_read(adr(0, 4), 32'hFF, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL mask0_read: got %h expected %h", got, e); end
    bus_write(adr(5, 0), 32'hDEAD_BEEF);
    bus_write(adr(7, 4), 32'hDEAD_BEEF);
    bus_write(adr(1, 5), 32'hDEAD_BEEF);
    bus_write(adr(4, 5), 32'hDEAD_BEEF);
    bus_write(adr(4, 1), 32'hDEAD_BEEF);
    bus_read(adr(1, 0), 32'h01CE, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL unmapped_wr_data1: got %h expected %h", got, e); end
    bus_read(adr(1, 4), 32'h0, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL unmapped_wr_mask1: got %h expected %h", got, e); end
    bus_read(adr(4, 0), 32'h2, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL unmapped_wr_div: got %h expected %h", got, e); end
    bus_read(adr(1, 5), 32'h0, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL reserved_read: got %h expected %h", got, e); end
    exp_q.push_back(32'hA5);
    address = adr(2, 0); writedata = 32'h55; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    tick();
    got = readdata; e = exp_q.pop_front();
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL wr_rd_prewrite: got %h expected %h", got, e); end
    bus_read(adr(2, 0), 32'h55, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL wr_rd_postwrite: got %h expected %h", got, e); end
    bus_write(adr(4, 0), 32'd0);
  endtask

  task automatic test_reset_mid_blink();
    logic [31:0] got, e;
    bus_write(adr(3, 4), 32'hF0F0);
    bus_write(adr(4, 0), 32'd2);
    repeat (3) tick();
    n_checks++; if (blink_phase !== 1'b1) begin n_errors++; $display("[TB] FAIL pre_reset_phase: got %b expected 1", blink_phase); end
    reset = 1'b1; address = adr(0, 0); writedata = 32'hDEAD; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    tick();
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    n_checks++; if (blink_phase !== 1'b0) begin n_errors++; $display("[TB] FAIL midreset_phase: got %b expected 0", blink_phase); end
    n_checks++; if (out_port !== {NUM_CH{32'hA5}}) begin n_errors++; $display("[TB] FAIL midreset_out_port: got %h expected %h", out_port, {NUM_CH{32'hA5}}); end
    n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("[TB] FAIL midreset_readdata: got %h expected 0", readdata); end
    bus_read(adr(3, 4), 32'h0, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL midreset_mask3: got %h expected %h", got, e); end
    bus_read(adr(0, 0), 32'hA5, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL reset_beats_write: got %h expected %h", got, e); end
    bus_read(adr(4, 0), 32'h0, got); e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_errors++; $display("[TB] FAIL midreset_div: got %h expected %h", got, e); end
    repeat (8) tick();
    n_checks++; if (blink_phase !== 1'b0) begin n_errors++; $display("[TB] FAIL post_reset_phase: got %b expected 0", blink_phase); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = '0;
    test_reset();
    test_atomics();
    test_blink();
    test_div_write();
    test_read_decode();
    test_reset_mid_blink();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
